// File: rtl/tse_ahbm_arbiter.sv
// Two-master (TSE TX/RX DMA) to one-master AHB arbiter with round-robin
// regrant on idle or after MAX_BEATS accepted beats by the current owner.
module tse_ahbm_arbiter #(
  parameter int unsigned MAX_BEATS   = 16,
  parameter int unsigned BEAT_CW     = 5,
  parameter bit          PARK_MASTER = 1'b0
) (
  input  logic        HCLK_I,
  input  logic        HRESET_NI,
  input  logic        TX_HSEL_I,
  input  logic [1:0]  TX_HTRANS_I,
  input  logic [31:0] TX_HADDR_I,
  input  logic        TX_HWRITE_I,
  input  logic [31:0] TX_HWDATA_I,
  input  logic        RX_HSEL_I,
  input  logic [1:0]  RX_HTRANS_I,
  input  logic [31:0] RX_HADDR_I,
  input  logic        RX_HWRITE_I,
  input  logic [31:0] RX_HWDATA_I,
  output logic        TX_HGRANT_O,
  output logic        RX_HGRANT_O,
  output logic        TX_HREADY_O,
  output logic        RX_HREADY_O,
  output logic [1:0]  TX_HRESP_O,
  output logic [1:0]  RX_HRESP_O,
  output logic [31:0] TX_HRDATA_O,
  output logic [31:0] RX_HRDATA_O,
  output logic        M_HSEL_O,
  output logic [1:0]  M_HTRANS_O,
  output logic [31:0] M_HADDR_O,
  output logic        M_HWRITE_O,
  output logic [31:0] M_HWDATA_O,
  output logic [2:0]  M_HBURST_O,
  output logic [2:0]  M_HSIZE_O,
  output logic        M_HMASTER_O,
  input  logic        M_HREADY_I,
  input  logic [1:0]  M_HRESP_I,
  input  logic [31:0] M_HRDATA_I
);

  typedef enum logic {
    OWN_TX = 1'b0,
    OWN_RX = 1'b1
  } owner_e;

  localparam owner_e                PARK     = owner_e'(PARK_MASTER);
  localparam logic [BEAT_CW-1:0]    LAST_CNT = BEAT_CW'(MAX_BEATS - 1);

  owner_e              r_addr_owner;
  owner_e              r_data_owner;
  logic                r_data_active;
  logic [BEAT_CW-1:0]  r_beat_cnt;

  logic                w_beat;
  logic                w_idle;
  logic                w_switch;

  always_comb begin
    if (r_addr_owner == OWN_RX) begin
      M_HSEL_O   = RX_HSEL_I;
      M_HTRANS_O = RX_HTRANS_I;
      M_HADDR_O  = RX_HADDR_I;
      M_HWRITE_O = RX_HWRITE_I;
    end else begin
      M_HSEL_O   = TX_HSEL_I;
      M_HTRANS_O = TX_HTRANS_I;
      M_HADDR_O  = TX_HADDR_I;
      M_HWRITE_O = TX_HWRITE_I;
    end
    M_HWDATA_O = (r_data_owner == OWN_RX) ? RX_HWDATA_I : TX_HWDATA_I;
  end

  assign M_HBURST_O  = 3'b001;
  assign M_HSIZE_O   = 3'b010;
  assign M_HMASTER_O = r_addr_owner;

  assign TX_HGRANT_O = (r_addr_owner == OWN_TX);
  assign RX_HGRANT_O = (r_addr_owner == OWN_RX);

  assign TX_HREADY_O = M_HREADY_I;
  assign RX_HREADY_O = M_HREADY_I;
  assign TX_HRDATA_O = M_HRDATA_I;
  assign RX_HRDATA_O = M_HRDATA_I;

  assign TX_HRESP_O = (r_data_active && r_data_owner == OWN_TX) ? M_HRESP_I : 2'b00;
  assign RX_HRESP_O = (r_data_active && r_data_owner == OWN_RX) ? M_HRESP_I : 2'b00;

  // BUSY is neither a beat nor idle, so it holds both owner and count.
  assign w_beat   = M_HTRANS_O[1];
  assign w_idle   = (M_HTRANS_O == 2'b00);
  assign w_switch = w_idle || (w_beat && r_beat_cnt == LAST_CNT);

  always_ff @(posedge HCLK_I or negedge HRESET_NI) begin
    if (!HRESET_NI) begin
      r_addr_owner  <= PARK;
      r_data_owner  <= PARK;
      r_data_active <= 1'b0;
      r_beat_cnt    <= '0;
    end else if (M_HREADY_I) begin
      r_data_owner  <= r_addr_owner;
      r_data_active <= w_beat;
      if (w_switch) begin
        r_addr_owner <= (r_addr_owner == OWN_TX) ? OWN_RX : OWN_TX;
        r_beat_cnt   <= '0;
      end else if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tse_ahbm_arbiter.sv
// Bench for tse_ahbm_arbiter: directed scenarios plus randomized traffic,
// all outputs compared each cycle against a behavioural ownership model.
module tb_tse_ahbm_arbiter;

  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_hsel, rx_hsel, tx_hwrite, rx_hwrite;
  logic [1:0]  tx_htrans, rx_htrans;
  logic [31:0] tx_haddr, rx_haddr, tx_hwdata, rx_hwdata;
  logic        tx_hgrant, rx_hgrant, tx_hready, rx_hready;
  logic [1:0]  tx_hresp, rx_hresp;
  logic [31:0] tx_hrdata, rx_hrdata;
  logic        m_hsel, m_hwrite, m_hmaster;
  logic [1:0]  m_htrans;
  logic [31:0] m_haddr, m_hwdata;
  logic [2:0]  m_hburst, m_hsize;
  logic        m_hready;
  logic [1:0]  m_hresp;
  logic [31:0] m_hrdata;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the bus, who owns the data phase, beats taken.
  int m_owner, m_downer, m_dactive, m_beats;

  always #5 clk = ~clk;

  tse_ahbm_arbiter #(.MAX_BEATS(16), .BEAT_CW(5), .PARK_MASTER(1'b0)) dut (
    .HCLK_I(clk), .HRESET_NI(rst_n),
    .TX_HSEL_I(tx_hsel), .TX_HTRANS_I(tx_htrans), .TX_HADDR_I(tx_haddr),
    .TX_HWRITE_I(tx_hwrite), .TX_HWDATA_I(tx_hwdata),
    .RX_HSEL_I(rx_hsel), .RX_HTRANS_I(rx_htrans), .RX_HADDR_I(rx_haddr),
    .RX_HWRITE_I(rx_hwrite), .RX_HWDATA_I(rx_hwdata),
    .TX_HGRANT_O(tx_hgrant), .RX_HGRANT_O(rx_hgrant),
    .TX_HREADY_O(tx_hready), .RX_HREADY_O(rx_hready),
    .TX_HRESP_O(tx_hresp), .RX_HRESP_O(rx_hresp),
    .TX_HRDATA_O(tx_hrdata), .RX_HRDATA_O(rx_hrdata),
    .M_HSEL_O(m_hsel), .M_HTRANS_O(m_htrans), .M_HADDR_O(m_haddr),
    .M_HWRITE_O(m_hwrite), .M_HWDATA_O(m_hwdata), .M_HBURST_O(m_hburst),
    .M_HSIZE_O(m_hsize), .M_HMASTER_O(m_hmaster),
    .M_HREADY_I(m_hready), .M_HRESP_I(m_hresp), .M_HRDATA_I(m_hrdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_downer = 0; m_dactive = 0; m_beats = 0;
  endtask

  // Compare every output against what the model says it should be now.
  task automatic check_model(input string tag);
    logic [63:0] a_exp, a_obs;
    logic [1:0]  own_trans;
    own_trans = m_owner ? rx_htrans : tx_htrans;
    a_exp = m_owner ? {29'd0, rx_hsel, rx_hwrite, 1'b1, rx_haddr}
                    : {29'd0, tx_hsel, tx_hwrite, 1'b0, tx_haddr};
    a_obs = {29'd0, m_hsel, m_hwrite, m_hmaster, m_haddr};
    chk({tag, ".grant"}, {62'd0, tx_hgrant, rx_hgrant}, {62'd0, m_owner == 0, m_owner == 1});
    chk({tag, ".addr"}, a_obs, a_exp);
    chk({tag, ".trans"}, {62'd0, m_htrans}, {62'd0, own_trans});
    chk({tag, ".wdata"}, {32'd0, m_hwdata}, {32'd0, m_downer ? rx_hwdata : tx_hwdata});
    chk({tag, ".resp"}, {60'd0, tx_hresp, rx_hresp},
        {60'd0, (m_dactive && m_downer == 0) ? m_hresp : 2'b00,
                (m_dactive && m_downer == 1) ? m_hresp : 2'b00});
    chk({tag, ".pass"}, {m_hrdata, tx_hrdata ^ rx_hrdata, 24'd0, tx_hready, rx_hready, m_hburst, m_hsize},
        {tx_hrdata, 32'd0, 24'd0, m_hready, m_hready, 3'b001, 3'b010});
  endtask

  // Check current outputs, then clock one edge and advance the model.
  task automatic cycle(input string tag);
    int t;
    #1;
    check_model(tag);
    t = m_owner ? int'(rx_htrans) : int'(tx_htrans);
    @(posedge clk);
    if (m_hready) begin
      m_downer  = m_owner;
      m_dactive = (t >= 2);
      if (t == 0 || (t >= 2 && m_beats + 1 == MAXB)) begin
        m_owner = 1 - m_owner;
        m_beats = 0;
      end else if (t >= 2) begin
        m_beats = m_beats + 1;
      end
    end
    #1;
  endtask

  initial begin
    logic was_tx;
    rst_n = 1'b0;
    tx_hsel = 1'b1; rx_hsel = 1'b1; tx_hwrite = 1'b0; rx_hwrite = 1'b1;
    tx_htrans = 2'b00; rx_htrans = 2'b00;
    tx_haddr = 32'h0; rx_haddr = 32'h0; tx_hwdata = 32'h0; rx_hwdata = 32'h0;
    m_hready = 1'b1; m_hresp = 2'b00; m_hrdata = 32'h1234_5678;
    model_reset();

    // Reset state and idle ping-pong park
    #3;
    chk("rst.grant", {62'd0, tx_hgrant, rx_hgrant}, 64'd2);
    chk("rst.const", {58'd0, m_hburst, m_hsize}, {58'd0, 3'b001, 3'b010});
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      was_tx = tx_hgrant;
      cycle("park");
      chk("park.toggle", {63'd0, tx_hgrant}, {63'd0, ~was_tx});
    end

    // TX 5-beat burst, RX waiting with NONSEQ at 0x8000
    rx_htrans = 2'b10; rx_haddr = 32'h8000;
    for (int i = 0; i < 5; i++) begin
      tx_htrans = (i == 0) ? 2'b10 : 2'b11;
      tx_haddr  = 32'h1000 + 32'(4 * i);
      #1;
      chk("tx_burst.addr", {32'd0, m_haddr}, {32'd0, 32'h1000 + 32'(4 * i)});
      cycle("tx_burst");
    end
    tx_htrans = 2'b00;
    cycle("tx_idle");
    chk("sw_rx.addr", {32'd0, m_haddr}, 64'h8000);
    chk("sw_rx.grant", {62'd0, tx_hgrant, rx_hgrant}, 64'd1);

    // RX continuous burst hits the beat limit
    tx_htrans = 2'b10; tx_haddr = 32'h2000;
    for (int i = 0; i < MAXB; i++) begin
      rx_htrans = (i == 0) ? 2'b10 : 2'b11;
      rx_haddr  = 32'h8000 + 32'(4 * i);
      rx_hwdata = 32'hA000_0000 + 32'(i);
      chk("rx_burst.grant", {63'd0, rx_hgrant}, 64'd1);
      cycle("rx_burst");
    end
    rx_hwdata = 32'hA000_0010;
    #1;
    chk("limit.grant", {62'd0, tx_hgrant, rx_hgrant}, 64'd2);
    chk("limit.wdata", {32'd0, m_hwdata}, {32'd0, 32'hA000_0010});

    // HREADY low during RX write data phase
    tx_htrans = 2'b00;
    cycle("to_rx");
    rx_htrans = 2'b10; rx_hwrite = 1'b1; rx_haddr = 32'h9000;
    cycle("rx_wr_addr");
    rx_htrans = 2'b00; rx_hwdata = 32'hDEAD_BEEF; m_hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle("wait");
      chk("wait.grant", {62'd0, tx_hgrant, rx_hgrant}, 64'd1);
      chk("wait.wdata", {32'd0, m_hwdata}, 64'hDEAD_BEEF);
    end
    m_hready = 1'b1;
    cycle("wait_end");
    chk("wait_end.grant", {62'd0, tx_hgrant, rx_hgrant}, 64'd2);

    // ERROR response on TX read data phase
    tx_htrans = 2'b10; tx_hwrite = 1'b0; tx_haddr = 32'h3000;
    cycle("tx_rd_addr");
    tx_htrans = 2'b00; m_hresp = 2'b01; m_hready = 1'b0;
    #1;
    chk("err1.resp", {60'd0, tx_hresp, rx_hresp}, 64'h4);
    cycle("err1");
    m_hready = 1'b1;
    #1;
    chk("err2.resp", {60'd0, tx_hresp, rx_hresp}, 64'h4);
    chk("err2.grant", {62'd0, tx_hgrant, rx_hgrant}, 64'd2);
    cycle("err2");
    m_hresp = 2'b00;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tx_htrans = 2'($urandom_range(0, 3));
      rx_htrans = ($urandom_range(0, 3) == 0) ? 2'b01 : (($urandom_range(0, 7) == 0) ? 2'b00 : 2'b11);
      tx_haddr  = {$urandom, 2'b00} >> 2 << 2;
      rx_haddr  = $urandom & 32'hFFFF_FFFC;
      tx_hwdata = $urandom; rx_hwdata = $urandom;
      tx_hsel   = 1'($urandom); rx_hsel = 1'($urandom);
      tx_hwrite = 1'($urandom); rx_hwrite = 1'($urandom);
      m_hready  = ($urandom_range(0, 3) != 0);
      m_hresp   = 2'($urandom_range(0, 3));
      m_hrdata  = $urandom;
      cycle("rand");
    end

    // Reset mid-burst: RX owner with 7 beats accepted
    m_hready = 1'b1; m_hresp = 2'b00;
    tx_htrans = 2'b00; rx_htrans = 2'b10;
    if (m_owner == 1) begin
      rx_htrans = 2'b00;
      cycle("align");
      rx_htrans = 2'b10;
    end
    cycle("to_rx2");
    for (int i = 0; i < 7; i++) begin
      rx_htrans = (i == 0) ? 2'b10 : 2'b11;
      cycle("rx7");
    end
    chk("pre_rst.grant", {62'd0, tx_hgrant, rx_hgrant}, 64'd1);
    chk("pre_rst.beats", 64'(m_beats), 64'd7);
    m_hresp = 2'b01;
    #1;
    chk("pre_rst.resp", {60'd0, tx_hresp, rx_hresp}, 64'h1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mid.grant", {62'd0, tx_hgrant, rx_hgrant}, 64'd2);
    chk("rst_mid.resp", {60'd0, tx_hresp, rx_hresp}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Beat counter restarted: TX takes a full MAX_BEATS run before regrant
    tx_htrans = 2'b10; m_hresp = 2'b00;
    for (int i = 0; i < MAXB; i++) begin
      chk("post_rst.grant", {63'd0, tx_hgrant}, 64'd1);
      cycle("post_rst");
      tx_htrans = 2'b11;
    end
    chk("post_rst.regrant", {62'd0, tx_hgrant, rx_hgrant}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
